// File: rtl/qspi_req_arb_if.sv
// Requester/core bundle between two requesters, the arbiter and the qspi_core register port.
// slave = arbiter side, master = requesters plus core side.
interface qspi_req_arb_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic [1:0]          req_i;
    logic [1:0]          we_i;
    logic [2*AW-1:0]     addr_i;
    logic [2*DW-1:0]     wdata_i;
    logic [2*DW/8-1:0]   be_i;
    logic [1:0]          gnt_o;
    logic [1:0]          rvalid_o;
    logic [DW-1:0]       rdata_o;
    logic                rerr_o;
    logic                core_re_o;
    logic                core_we_o;
    logic [AW-1:0]       core_addr_o;
    logic [DW-1:0]       core_wdata_o;
    logic [DW/8-1:0]     core_be_o;
    logic [DW-1:0]       core_rdata_i;
    logic                core_done_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, core_rdata_i, core_done_i,
        output gnt_o, rvalid_o, rdata_o, rerr_o,
        output core_re_o, core_we_o, core_addr_o, core_wdata_o, core_be_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, core_rdata_i, core_done_i,
        input  gnt_o, rvalid_o, rdata_o, rerr_o,
        input  core_re_o, core_we_o, core_addr_o, core_wdata_o, core_be_o
    );
endinterface

// File: rtl/qspi_req_arb.sv
// Two-requester round-robin arbiter in front of the qspi_core register port.
// Define QSPI_ARB_TIMEOUT_EN to add a read-wait timeout that returns an error response.
module qspi_req_arb #(
    parameter int AW        = 24,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 1024
) (
    input logic          clk_i,
    input logic          rst_ni,
    qspi_req_arb_if.slave bus
);

    localparam int BW = DW / 8;

    if (TO_CYCLES < 2) begin : g_to_check
        $error("qspi_req_arb: TO_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RSP} state_e;

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic            last_q, last_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [1:0]      gnt_c;
    logic            win;

`ifdef QSPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES);
    localparam logic [CW-1:0] TO_LIM = CW'(TO_CYCLES - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        rvalid_d = 2'b00;
        gnt_c    = 2'b00;
        win      = 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_i != 2'b00) begin
                    // On a tie the requester that did not win last time goes first.
                    win     = (bus.req_i == 2'b11) ? ~last_q : bus.req_i[1];
                    sel_d   = win;
                    last_d  = win;
                    we_d    = bus.we_i[win];
                    addr_d  = win ? bus.addr_i[AW +: AW]    : bus.addr_i[0 +: AW];
                    wdata_d = win ? bus.wdata_i[DW +: DW]   : bus.wdata_i[0 +: DW];
                    be_d    = win ? bus.be_i[BW +: BW]      : bus.be_i[0 +: BW];
                    if (bus.we_i[win]) begin
                        gnt_c[win] = 1'b1;
                        state_d    = WR;
                    end else begin
                        state_d    = RD_WAIT;
                    end
`ifdef QSPI_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            WR: state_d = IDLE;
            RD_WAIT: begin
`ifdef QSPI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CW'(1);
`endif
                // A requester that drops its request before grant has withdrawn it.
                if (!bus.req_i[sel_q]) begin
                    state_d = IDLE;
                end else if (bus.core_done_i) begin
                    gnt_c[sel_q] = 1'b1;
                    rdata_d      = bus.core_rdata_i;
                    state_d      = RSP;
`ifdef QSPI_ARB_TIMEOUT_EN
                    err_d        = 1'b0;
                end else if (cnt_q == TO_LIM) begin
                    gnt_c[sel_q] = 1'b1;
                    rdata_d      = '0;
                    err_d        = 1'b1;
                    state_d      = RSP;
`endif
                end
            end
            RSP: begin
                rvalid_d[sel_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
`ifdef QSPI_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef QSPI_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Grant is combinational from req_i, so it is masked while reset is held.
    assign bus.gnt_o        = gnt_c & {2{rst_ni}};
    assign bus.rvalid_o     = rvalid_q;
    assign bus.rdata_o      = rdata_q;
`ifdef QSPI_ARB_TIMEOUT_EN
    assign bus.rerr_o       = err_q & (|rvalid_q);
`else
    assign bus.rerr_o       = 1'b0;
`endif
    assign bus.core_we_o    = (state_q == WR);
    assign bus.core_re_o    = (state_q == RD_WAIT);
    assign bus.core_addr_o  = (state_q == WR)      ? {addr_q[AW-3:0], 2'b00} :
                              (state_q == RD_WAIT) ? addr_q : '0;
    assign bus.core_wdata_o = wdata_q;
    assign bus.core_be_o    = be_q;

endmodule

// File: tb/tb_qspi_req_arb.sv
// Directed bench for qspi_req_arb: writes, reads, round-robin, reset abort and,
// when QSPI_ARB_TIMEOUT_EN is defined, the read timeout paths.
module tb_qspi_req_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [23:0] a0, a1;
    logic [31:0] d0, d1, crd;
    logic [3:0]  b0, b1;
    logic        done;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    qspi_req_arb_if #(.AW(24), .DW(32)) bus ();

    assign bus.req_i        = req;
    assign bus.we_i         = we;
    assign bus.addr_i       = {a1, a0};
    assign bus.wdata_i      = {d1, d0};
    assign bus.be_i         = {b1, b0};
    assign bus.core_rdata_i = crd;
    assign bus.core_done_i  = done;

    qspi_req_arb #(.AW(24), .DW(32), .TO_CYCLES(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req = 2'b01; we = 2'b01; a0 = '0; a1 = '0;
        d0 = '0; d1 = '0; b0 = '0; b1 = '0; done = 1'b0; crd = '0;
        step(); step(); #1;
        chk("rst_gnt", bus.gnt_o, 2'b00);
        chk("rst_core_we", bus.core_we_o, 1'b0);
        chk("rst_rvalid", bus.rvalid_o, 2'b00);
        req = 2'b00; we = 2'b00; rst_n = 1'b1;
        step();

        // Single write from requester 0
        req = 2'b01; we = 2'b01; a0 = 24'h000010; d0 = 32'hA5A5A5A5; b0 = 4'hF; #1;
        chk("wr_gnt", bus.gnt_o, 2'b01);
        chk("wr_we_early", bus.core_we_o, 1'b0);
        step(); req = 2'b00; #1;
        chk("wr_core_we", bus.core_we_o, 1'b1);
        chk("wr_core_addr", bus.core_addr_o, 24'h000040);
        chk("wr_core_wdata", bus.core_wdata_o, 32'hA5A5A5A5);
        chk("wr_core_be", bus.core_be_o, 4'hF);
        chk("wr_gnt_off", bus.gnt_o, 2'b00);
        step(); #1;
        chk("wr_we_one_cycle", bus.core_we_o, 1'b0);

        // core_done_i in IDLE is ignored
        done = 1'b1; #1;
        chk("idle_done_gnt", bus.gnt_o, 2'b00);
        step(); done = 1'b0; #1;
        chk("idle_done_re", bus.core_re_o, 1'b0);
        chk("idle_done_rvalid", bus.rvalid_o, 2'b00);

        // Read from requester 1, done five cycles after selection
        req = 2'b10; we = 2'b00; a1 = 24'h000123; #1;
        chk("rd_no_gnt_sel", bus.gnt_o, 2'b00);
        step(); #1;
        chk("rd_core_re", bus.core_re_o, 1'b1);
        chk("rd_core_addr", bus.core_addr_o, 24'h000123);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("rd_wait_gnt", bus.gnt_o, 2'b00);
        end
        done = 1'b1; crd = 32'hDEADBEEF; #1;
        chk("rd_done_gnt", bus.gnt_o, 2'b10);
        step(); done = 1'b0; req = 2'b00; crd = '0; #1;
        chk("rd_re_drop", bus.core_re_o, 1'b0);
        chk("rd_rvalid_early", bus.rvalid_o, 2'b00);
        step(); #1;
        chk("rd_rvalid", bus.rvalid_o, 2'b10);
        chk("rd_rdata", bus.rdata_o, 32'hDEADBEEF);
        chk("rd_rerr", bus.rerr_o, 1'b0);
        step(); #1;
        chk("rd_rvalid_off", bus.rvalid_o, 2'b00);
        chk("rd_rdata_hold", bus.rdata_o, 32'hDEADBEEF);

        // Both requesters writing back to back
        req = 2'b11; we = 2'b11; a0 = 24'h000001; a1 = 24'h000002;
        d0 = 32'h11111111; d1 = 32'h22222222; b1 = 4'h3; #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_gnt", bus.gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            step(); #1;
            chk("rr_gap", bus.gnt_o, 2'b00);
            chk("rr_core_we", bus.core_we_o, 1'b1);
            chk("rr_core_addr", bus.core_addr_o, (i % 2 == 0) ? 24'h000004 : 24'h000008);
            step(); #1;
        end
        req = 2'b00; we = 2'b00; #1;

`ifdef QSPI_ARB_TIMEOUT_EN
        // Timeout with no core_done_i
        req = 2'b10; a1 = 24'h000077; #1;
        for (int i = 1; i <= 16; i++) begin
            step(); #1;
            chk("to_re", bus.core_re_o, 1'b1);
            chk("to_gnt", bus.gnt_o, (i < 16) ? 2'b00 : 2'b10);
        end
        step(); req = 2'b00; #1;
        chk("to_re_drop", bus.core_re_o, 1'b0);
        step(); #1;
        chk("to_rvalid", bus.rvalid_o, 2'b10);
        chk("to_rerr", bus.rerr_o, 1'b1);
        chk("to_rdata", bus.rdata_o, 32'h0);
        step(); #1;

        // core_done_i on the timeout cycle wins
        req = 2'b10; #1;
        for (int i = 1; i < 16; i++) step();
        step(); done = 1'b1; crd = 32'h12345678; #1;
        chk("tie_gnt", bus.gnt_o, 2'b10);
        step(); done = 1'b0; req = 2'b00; #1;
        step(); #1;
        chk("tie_rvalid", bus.rvalid_o, 2'b10);
        chk("tie_rerr", bus.rerr_o, 1'b0);
        chk("tie_rdata", bus.rdata_o, 32'h12345678);
        step(); #1;
`else
        // No timeout: a long read wait just keeps waiting
        req = 2'b10; a1 = 24'h000077; #1;
        for (int i = 1; i <= 20; i++) begin
            step(); #1;
            chk("nto_re", bus.core_re_o, 1'b1);
            chk("nto_gnt", bus.gnt_o, 2'b00);
        end
        done = 1'b1; crd = 32'hCAFEF00D; #1;
        chk("nto_done_gnt", bus.gnt_o, 2'b10);
        step(); done = 1'b0; req = 2'b00; #1;
        step(); #1;
        chk("nto_rvalid", bus.rvalid_o, 2'b10);
        chk("nto_rerr", bus.rerr_o, 1'b0);
        chk("nto_rdata", bus.rdata_o, 32'hCAFEF00D);
        step(); #1;
`endif

        // Reset during RD_WAIT aborts the read
        req = 2'b01; we = 2'b00; a0 = 24'h000055; #1;
        step(); #1;
        chk("ra_core_re", bus.core_re_o, 1'b1);
        chk("ra_core_addr", bus.core_addr_o, 24'h000055);
        rst_n = 1'b0; #1;
        chk("ra_gnt", bus.gnt_o, 2'b00);
        chk("ra_rvalid", bus.rvalid_o, 2'b00);
        chk("ra_rdata", bus.rdata_o, 32'h0);
        chk("ra_rerr", bus.rerr_o, 1'b0);
        chk("ra_core_re0", bus.core_re_o, 1'b0);
        chk("ra_core_we", bus.core_we_o, 1'b0);
        chk("ra_core_addr0", bus.core_addr_o, 24'h0);
        chk("ra_core_wdata", bus.core_wdata_o, 32'h0);
        chk("ra_core_be", bus.core_be_o, 4'h0);
        req = 2'b00;
        step(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("ra_no_rvalid", bus.rvalid_o, 2'b00);
            chk("ra_no_gnt", bus.gnt_o, 2'b00);
        end
        req = 2'b11; we = 2'b11; #1;
        chk("ra_tie_gnt", bus.gnt_o, 2'b01);
        step(); req = 2'b00; we = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
